axis_stall_detector: RTL and testbench
======================================

Name: axis_stall_detector

Overview:
- Per-channel AXI-Stream stall watchdog for the dataflow co-simulation harness.
- Observes the TVALID/TREADY pair and the consumer-idle flag of each AXIS channel.
- Raises a registered per-channel block flag once a channel stays stalled for STALL_LIMIT consecutive cycles.
- Produces the axis_block_sigs vector consumed by the deadlock monitor, and queues blocked-channel events to a valid/ready report port for the bench logger.

Parameters:
- NUM_CH, 5, number of monitored AXIS channels (1..8).
- CNT_W, 16, stall counter width; must satisfy STALL_LIMIT < 2**CNT_W.
- STALL_LIMIT, 1024, consecutive stalled cycles before block asserts (>=2).
- IDX_W, 3, channel index width; must satisfy 2**IDX_W >= NUM_CH.
- FIFO_DEPTH, 4, event queue depth (power of two, >=2).

Ports:
- clock, input, 1, clock
- reset, input, 1, synchronous, active-high reset
- enable, input, 1, monitoring enable; low clears counters, states and block flags (FIFO kept)
- ch_tvalid, input, NUM_CH, per-channel TVALID
- ch_tready, input, NUM_CH, per-channel TREADY
- inst_idle, input, NUM_CH, consumer-idle flag per channel (1 = consumer not waiting on data)
- axis_block_sigs, output, NUM_CH, registered per-channel blocked flag
- any_block, output, 1, registered OR of all block flags
- report_valid, output, 1, event available
- report_ready, input, 1, logger accepts event
- report_data, output, IDX_W+1, {kind, idx}; kind 1 = full (back-pressure), 0 = empty (starvation)
- report_count, output, IDX_W+1, events currently held in FIFO (0..FIFO_DEPTH)

Behaviour:
- Reset: all outputs 0, all counters 0, all channel states OK, FIFO empty, pending vector 0.
- Per-channel FSM, evaluated each cycle while enable=1:
  - OK: valid&!ready -> FULL with cnt=1; !valid&ready&!idle -> EMPTY with cnt=1; otherwise stay, cnt=0.
  - FULL: valid&!ready -> cnt++; at cnt==STALL_LIMIT-1 (still stalled) -> BLOCKED_FULL and block flag set next edge. Any other condition -> OK, cnt=0.
  - EMPTY: !valid&ready&!idle -> cnt++; same limit rule -> BLOCKED_EMPTY. Otherwise -> OK. Valid rising without a transfer -> FULL, cnt=1.
  - BLOCKED_x: block flag held 1. Handshake (valid&ready) -> OK, cnt=0, flag 0 next edge. Stall kind switching -> other stall state, cnt=1, flag 0.
- !valid&!ready, or idle=1 with no valid, is not a stall; the channel returns to OK.
- A transfer always clears that channel's counter the same edge.
- Latency: block flag reads 1 in the cycle immediately following the STALL_LIMIT-th consecutive stalled cycle; it drops in the cycle after the clearing handshake.
- Counter never wraps; it stops incrementing in BLOCKED states.
- Event generation: entry into any BLOCKED state sets pending[i] and records kind[i].
  - Each cycle the lowest-index pending channel is pushed if the FIFO is not full, or is full and popping this cycle; its pending bit then clears.
  - At most one push per cycle. Pending bits are never lost while the FIFO is full.
  - A channel that leaves BLOCKED before its push clears its pending bit; no event is generated.
- Report port: report_valid = FIFO non-empty; pop on report_valid & report_ready.
  - report_data is stable while valid and not accepted.
  - report_count updates the edge after push/pop; simultaneous push and pop leaves it unchanged.
- enable low: same-edge reset of counters, FSMs, block flags and pending bits. FIFO contents remain drainable.
- Reset asserted mid-operation: everything clears on that edge, including the FIFO.

Test Plan:
- Back-pressure: STALL_LIMIT=8; ch2 valid=1, ready=0 from cycle 0 -> axis_block_sigs=5'b00100 at cycle 8, not 7. Report emits {1,2}. ready=1 at cycle 12 -> flag 0 at cycle 13.
- Starvation: ch0 ready=1, valid=0, idle=0 for 8 cycles -> bit0 set, report {0,0}. Repeat with idle=1 -> no flag, no event.
- Interrupted stall: ch1 stalled 7 cycles, one transfer, then stalled 7 more -> flag never asserts, report_count stays 0.
- Simultaneous: ch3 and ch1 block on the same cycle with report_ready=0 -> events {1,1} then {1,3} queued in consecutive cycles; report_count reaches 2.
- FIFO full: FIFO_DEPTH=4, block all 5 channels with report_ready=0 -> count=4, ch4 stays pending. One pop -> {x,4} pushed the same cycle, count stays 4.
- enable/reset: deassert enable while ch2 is BLOCKED -> flag 0 next cycle and the queued event is still readable. Assert reset -> report_valid=0, count=0.

Source files
------------

// File: rtl/axis_stall_detector_if.sv
// Channel observation and blocked-event report signals for the AXIS stall watchdog.
interface axis_stall_detector_if #(
    parameter int unsigned NUM_CH = 5,
    parameter int unsigned IDX_W  = 3
);
    logic [NUM_CH-1:0] ch_tvalid;
    logic [NUM_CH-1:0] ch_tready;
    logic [NUM_CH-1:0] inst_idle;
    logic [NUM_CH-1:0] axis_block_sigs;
    logic              any_block;
    logic              report_valid;
    logic              report_ready;
    logic [IDX_W:0]    report_data;
    logic [IDX_W:0]    report_count;

    // Harness side: drives the observed channels and consumes reports.
    modport master (
        output ch_tvalid, ch_tready, inst_idle, report_ready,
        input  axis_block_sigs, any_block, report_valid, report_data, report_count
    );

    // Watchdog side.
    modport slave (
        input  ch_tvalid, ch_tready, inst_idle, report_ready,
        output axis_block_sigs, any_block, report_valid, report_data, report_count
    );
endinterface

// File: rtl/axis_stall_detector.sv
// Per-channel AXI-Stream stall watchdog: counts consecutive stalled cycles per channel,
// raises a registered block flag at STALL_LIMIT and queues one event per blocking episode.
module axis_stall_detector #(
    parameter int unsigned NUM_CH      = 5,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned STALL_LIMIT = 1024,
    parameter int unsigned IDX_W       = 3,
    parameter int unsigned FIFO_DEPTH  = 4
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 enable,
    axis_stall_detector_if.slave bus
);
    localparam int unsigned      PtrW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [CNT_W-1:0] LimitM1   = CNT_W'(STALL_LIMIT - 1);
    localparam logic [CNT_W-1:0] LimitHold = CNT_W'(STALL_LIMIT);
    localparam logic [IDX_W:0]   DepthCnt  = (IDX_W + 1)'(FIFO_DEPTH);

    typedef enum logic [2:0] {StOk, StFull, StEmpty, StBlkFull, StBlkEmpty} ch_state_e;

    ch_state_e         state_q [NUM_CH];
    ch_state_e         state_d [NUM_CH];
    logic [CNT_W-1:0]  cnt_q   [NUM_CH];
    logic [CNT_W-1:0]  cnt_d   [NUM_CH];
    logic [NUM_CH-1:0] full_stall, empty_stall;
    logic [NUM_CH-1:0] blk_now, blk_next;
    logic [NUM_CH-1:0] block_q, pending_q, pending_d, push_sel;
    logic              any_block_q;

    logic [IDX_W:0]    mem_q [FIFO_DEPTH];
    logic [PtrW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [IDX_W:0]    count_q;
    logic              push_valid, push_kind, do_push, do_pop;
    logic [IDX_W-1:0]  push_idx;

    // Back-pressure: producer waiting. Starvation: consumer waiting on data.
    assign full_stall  = bus.ch_tvalid & ~bus.ch_tready;
    assign empty_stall = ~bus.ch_tvalid & bus.ch_tready & ~bus.inst_idle;

    // Per-channel stall FSM and consecutive-stall counter.
    always_comb begin
        blk_now  = '0;
        blk_next = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            state_d[i] = state_q[i];
            cnt_d[i]   = cnt_q[i];
            unique case (state_q[i])
                StOk: begin
                    if (full_stall[i]) begin
                        state_d[i] = StFull;
                        cnt_d[i]   = CNT_W'(1);
                    end else if (empty_stall[i]) begin
                        state_d[i] = StEmpty;
                        cnt_d[i]   = CNT_W'(1);
                    end else begin
                        cnt_d[i] = '0;
                    end
                end
                StFull: begin
                    if (full_stall[i]) begin
                        if (cnt_q[i] == LimitM1) begin
                            state_d[i] = StBlkFull;
                            cnt_d[i]   = LimitHold;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end else begin
                        state_d[i] = StOk;
                        cnt_d[i]   = '0;
                    end
                end
                StEmpty: begin
                    if (empty_stall[i]) begin
                        if (cnt_q[i] == LimitM1) begin
                            state_d[i] = StBlkEmpty;
                            cnt_d[i]   = LimitHold;
                        end else begin
                            cnt_d[i] = cnt_q[i] + CNT_W'(1);
                        end
                    end else if (full_stall[i]) begin
                        state_d[i] = StFull;
                        cnt_d[i]   = CNT_W'(1);
                    end else begin
                        state_d[i] = StOk;
                        cnt_d[i]   = '0;
                    end
                end
                StBlkFull: begin
                    if (empty_stall[i]) begin
                        state_d[i] = StEmpty;
                        cnt_d[i]   = CNT_W'(1);
                    end else if (!full_stall[i]) begin
                        state_d[i] = StOk;
                        cnt_d[i]   = '0;
                    end
                end
                StBlkEmpty: begin
                    if (full_stall[i]) begin
                        state_d[i] = StFull;
                        cnt_d[i]   = CNT_W'(1);
                    end else if (!empty_stall[i]) begin
                        state_d[i] = StOk;
                        cnt_d[i]   = '0;
                    end
                end
                default: begin
                    state_d[i] = StOk;
                    cnt_d[i]   = '0;
                end
            endcase
            if (!enable) begin
                state_d[i] = StOk;
                cnt_d[i]   = '0;
            end
            blk_now[i]  = (state_q[i] == StBlkFull) || (state_q[i] == StBlkEmpty);
            blk_next[i] = (state_d[i] == StBlkFull) || (state_d[i] == StBlkEmpty);
        end
    end

    // Lowest-index pending channel wins the single push slot; pending tracks unreported episodes.
    always_comb begin
        push_valid = 1'b0;
        push_idx   = '0;
        push_kind  = 1'b0;
        push_sel   = '0;
        for (int i = int'(NUM_CH) - 1; i >= 0; i--) begin
            if (pending_q[i]) begin
                push_valid  = 1'b1;
                push_idx    = IDX_W'(i);
                push_kind   = (state_q[i] == StBlkFull);
                push_sel    = '0;
                push_sel[i] = 1'b1;
            end
        end
        do_pop  = (count_q != '0) && bus.report_ready;
        // A full queue still accepts when it is popped in the same cycle.
        do_push = enable && push_valid && ((count_q != DepthCnt) || do_pop);
        // Masking with blk_next drops episodes that ended before being reported.
        pending_d = ((pending_q & ~({NUM_CH{do_push}} & push_sel)) & blk_next)
                  | (blk_next & ~blk_now);
        if (!enable) begin
            pending_d = '0;
        end
    end

    // Channel state, counters, flags and pending bits.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= StOk;
                cnt_q[i]   <= '0;
            end
            block_q     <= '0;
            any_block_q <= 1'b0;
            pending_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                state_q[i] <= state_d[i];
                cnt_q[i]   <= cnt_d[i];
            end
            block_q     <= blk_next;
            any_block_q <= |blk_next;
            pending_q   <= pending_d;
        end
    end

    // Event queue; kept across enable low so the logger can still drain it.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= {push_kind, push_idx};
                wr_ptr_q        <= wr_ptr_q + PtrW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + PtrW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + (IDX_W + 1)'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - (IDX_W + 1)'(1);
            end
        end
    end

    assign bus.axis_block_sigs = block_q;
    assign bus.any_block       = any_block_q;
    assign bus.report_valid    = (count_q != '0);
    assign bus.report_data     = mem_q[rd_ptr_q];
    assign bus.report_count    = count_q;
endmodule

// File: tb/tb_axis_stall_detector.sv
// Bench for axis_stall_detector: directed vector table, corner sequences, random vs run-length model.
module tb_axis_stall_detector;
    localparam int NumCh = 5;
    localparam int IdxW  = 3;
    localparam int Limit = 8;
    localparam int Depth = 4;

    logic clock  = 1'b0;
    logic reset  = 1'b1;
    logic enable = 1'b0;

    axis_stall_detector_if #(.NUM_CH(NumCh), .IDX_W(IdxW)) bus ();

    axis_stall_detector #(
        .NUM_CH     (NumCh),
        .CNT_W      (16),
        .STALL_LIMIT(Limit),
        .IDX_W      (IdxW),
        .FIFO_DEPTH (Depth)
    ) dut (
        .clock (clock),
        .reset (reset),
        .enable(enable),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // Model: length of the current same-kind stall run per channel (kind 1 full, 2 empty).
    int            m_run  [NumCh];
    int            m_kind [NumCh];
    bit            m_pend [NumCh];
    logic [IdxW:0] m_fifo [$];

    typedef struct {
        logic [NumCh-1:0] v, r, idl;
        logic             rrdy, en;
        int               n;
        logic [NumCh-1:0] blk;
        logic [IdxW:0]    cnt;
        logic [IdxW:0]    data;
    } vec_t;

    vec_t tbl [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int stall_kind(input int i);
        if (bus.ch_tvalid[i] && !bus.ch_tready[i]) return 1;
        if (!bus.ch_tvalid[i] && bus.ch_tready[i] && !bus.inst_idle[i]) return 2;
        return 0;
    endfunction

    task automatic model_update();
        bit            pop;
        int            push_i;
        int            s;
        bit            was, now;
        logic          k;
        logic [IdxW:0] ev;
        if (reset) begin
            for (int i = 0; i < NumCh; i++) begin
                m_run[i]  = 0;
                m_kind[i] = 0;
                m_pend[i] = 0;
            end
            m_fifo.delete();
            return;
        end
        pop    = (m_fifo.size() > 0) && bus.report_ready;
        push_i = -1;
        if (enable) begin
            for (int i = 0; i < NumCh; i++) begin
                if (m_pend[i] && push_i < 0) push_i = i;
            end
        end
        if (push_i >= 0 && m_fifo.size() >= Depth && !pop) push_i = -1;
        if (pop) void'(m_fifo.pop_front());
        if (push_i >= 0) begin
            k  = (m_kind[push_i] == 1);
            ev = {k, IdxW'(push_i)};
            m_fifo.push_back(ev);
            m_pend[push_i] = 0;
        end
        for (int i = 0; i < NumCh; i++) begin
            s   = stall_kind(i);
            was = (m_run[i] >= Limit);
            if (!enable || s == 0) begin
                m_run[i]  = 0;
                m_kind[i] = 0;
            end else if (s == m_kind[i]) begin
                if (m_run[i] < Limit) m_run[i]++;
            end else if (m_kind[i] == 1 && m_run[i] < Limit && s == 2) begin
                // An unblocked back-pressure run dropping into starvation restarts from idle.
                m_run[i]  = 0;
                m_kind[i] = 0;
            end else begin
                m_run[i]  = 1;
                m_kind[i] = s;
            end
            now = (m_run[i] >= Limit);
            if (!was && now) m_pend[i] = 1;
            if (was && !now) m_pend[i] = 0;
        end
    endtask

    task automatic compare_model();
        logic [NumCh-1:0] eb;
        for (int i = 0; i < NumCh; i++) eb[i] = (m_run[i] >= Limit);
        check("model block_sigs", bus.axis_block_sigs, eb);
        check("model any_block", bus.any_block, |eb);
        check("model report_valid", bus.report_valid, m_fifo.size() > 0);
        check("model report_count", bus.report_count, m_fifo.size());
        if (m_fifo.size() > 0) check("model report_data", bus.report_data, m_fifo[0]);
    endtask

    task automatic step();
        model_update();
        @(posedge clock);
        #1;
        compare_model();
    endtask

    task automatic drive(input logic [NumCh-1:0] v, input logic [NumCh-1:0] r,
                         input logic [NumCh-1:0] idl, input logic rrdy, input logic en);
        bus.ch_tvalid    = v;
        bus.ch_tready    = r;
        bus.inst_idle    = idl;
        bus.report_ready = rrdy;
        enable           = en;
    endtask

    function automatic vec_t mk(input logic [NumCh-1:0] v, input logic [NumCh-1:0] r,
                                input logic [NumCh-1:0] idl, input logic rrdy, input logic en,
                                input int n, input logic [NumCh-1:0] blk,
                                input logic [IdxW:0] cnt, input logic [IdxW:0] data);
        vec_t t;
        t.v = v; t.r = r; t.idl = idl; t.rrdy = rrdy; t.en = en;
        t.n = n; t.blk = blk; t.cnt = cnt; t.data = data;
        return t;
    endfunction

    logic [NumCh-1:0] rv, rr, ri;

    initial begin
        // Back-pressure on ch2: flag after the 8th stalled cycle, drops after the handshake.
        tbl.push_back(mk(5'b00100, 5'b00000, 5'b00000, 0, 1, 7, 5'b00000, 0, 4'b0000));
        tbl.push_back(mk(5'b00100, 5'b00000, 5'b00000, 0, 1, 1, 5'b00100, 0, 4'b0000));
        tbl.push_back(mk(5'b00100, 5'b00000, 5'b00000, 0, 1, 4, 5'b00100, 1, 4'b1010));
        tbl.push_back(mk(5'b00100, 5'b00100, 5'b00000, 0, 1, 1, 5'b00000, 1, 4'b1010));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 1, 1, 1, 5'b00000, 0, 4'b0000));
        // Starvation on ch0, then the same with the consumer idle.
        tbl.push_back(mk(5'b00000, 5'b00001, 5'b00000, 0, 1, 7, 5'b00000, 0, 4'b0000));
        tbl.push_back(mk(5'b00000, 5'b00001, 5'b00000, 0, 1, 1, 5'b00001, 0, 4'b0000));
        tbl.push_back(mk(5'b00000, 5'b00001, 5'b00000, 0, 1, 1, 5'b00001, 1, 4'b0000));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 1, 1, 1, 5'b00000, 0, 4'b0000));
        tbl.push_back(mk(5'b00000, 5'b00001, 5'b11111, 0, 1, 10, 5'b00000, 0, 4'b0000));
        // Interrupted stall on ch1.
        tbl.push_back(mk(5'b00010, 5'b00000, 5'b00000, 0, 1, 7, 5'b00000, 0, 4'b0000));
        tbl.push_back(mk(5'b00010, 5'b00010, 5'b00000, 0, 1, 1, 5'b00000, 0, 4'b0000));
        tbl.push_back(mk(5'b00010, 5'b00000, 5'b00000, 0, 1, 7, 5'b00000, 0, 4'b0000));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 0, 1, 1, 5'b00000, 0, 4'b0000));
        // ch1 and ch3 block together: ch1 queued first.
        tbl.push_back(mk(5'b01010, 5'b00000, 5'b00000, 0, 1, 8, 5'b01010, 0, 4'b0000));
        tbl.push_back(mk(5'b01010, 5'b00000, 5'b00000, 0, 1, 1, 5'b01010, 1, 4'b1001));
        tbl.push_back(mk(5'b01010, 5'b00000, 5'b00000, 0, 1, 1, 5'b01010, 2, 4'b1001));
        tbl.push_back(mk(5'b01010, 5'b00000, 5'b00000, 1, 1, 1, 5'b01010, 1, 4'b1011));
        tbl.push_back(mk(5'b00000, 5'b00000, 5'b00000, 1, 1, 1, 5'b00000, 0, 4'b0000));
        // All channels block, queue fills, ch4 waits and enters on the first pop.
        tbl.push_back(mk(5'b11111, 5'b00000, 5'b00000, 0, 1, 8, 5'b11111, 0, 4'b0000));
        tbl.push_back(mk(5'b11111, 5'b00000, 5'b00000, 0, 1, 4, 5'b11111, 4, 4'b1000));
        tbl.push_back(mk(5'b11111, 5'b00000, 5'b00000, 0, 1, 3, 5'b11111, 4, 4'b1000));
        tbl.push_back(mk(5'b11111, 5'b00000, 5'b00000, 1, 1, 1, 5'b11111, 4, 4'b1001));
        tbl.push_back(mk(5'b11111, 5'b00000, 5'b00000, 0, 1, 1, 5'b11111, 4, 4'b1001));
        tbl.push_back(mk(5'b11111, 5'b00000, 5'b00000, 1, 1, 3, 5'b11111, 1, 4'b1100));
        // Enable low clears flags but keeps the queued event.
        tbl.push_back(mk(5'b11111, 5'b00000, 5'b00000, 0, 0, 1, 5'b00000, 1, 4'b1100));
        tbl.push_back(mk(5'b11111, 5'b00000, 5'b00000, 0, 0, 2, 5'b00000, 1, 4'b1100));

        drive('0, '0, '0, 1'b0, 1'b0);
        reset = 1'b1;
        step();
        step();
        check("reset block_sigs", bus.axis_block_sigs, 0);
        check("reset any_block", bus.any_block, 0);
        check("reset report_valid", bus.report_valid, 0);
        check("reset report_count", bus.report_count, 0);
        check("reset report_data", bus.report_data, 0);
        reset = 1'b0;

        foreach (tbl[k]) begin
            drive(tbl[k].v, tbl[k].r, tbl[k].idl, tbl[k].rrdy, tbl[k].en);
            repeat (tbl[k].n) step();
            check($sformatf("vec%0d block_sigs", k), bus.axis_block_sigs, tbl[k].blk);
            check($sformatf("vec%0d any_block", k), bus.any_block, |tbl[k].blk);
            check($sformatf("vec%0d report_count", k), bus.report_count, tbl[k].cnt);
            check($sformatf("vec%0d report_valid", k), bus.report_valid, tbl[k].cnt != 0);
            if (tbl[k].cnt != 0)
                check($sformatf("vec%0d report_data", k), bus.report_data, tbl[k].data);
        end

        // Kind switch on ch0: blocked full -> starvation restarts the run at 1.
        drive(5'b00001, 5'b00000, 5'b00000, 1'b1, 1'b1);
        repeat (8) step();
        check("switch blocked full", bus.axis_block_sigs, 5'b00001);
        drive(5'b00000, 5'b00001, 5'b00000, 1'b1, 1'b1);
        step();
        check("switch flag drop", bus.axis_block_sigs, 5'b00000);
        repeat (6) step();
        check("switch not yet empty", bus.axis_block_sigs, 5'b00000);
        step();
        check("switch blocked empty", bus.axis_block_sigs, 5'b00001);

        // Reset mid-operation clears the queue too.
        drive(5'b00000, 5'b00000, 5'b00000, 1'b1, 1'b1);
        repeat (3) step();
        check("drained count", bus.report_count, 0);
        drive(5'b00100, 5'b00000, 5'b00000, 1'b0, 1'b1);
        repeat (9) step();
        check("pre-reset block", bus.axis_block_sigs, 5'b00100);
        check("pre-reset count", bus.report_count, 1);
        reset = 1'b1;
        step();
        check("mid reset block_sigs", bus.axis_block_sigs, 0);
        check("mid reset any_block", bus.any_block, 0);
        check("mid reset report_valid", bus.report_valid, 0);
        check("mid reset report_count", bus.report_count, 0);
        reset = 1'b0;

        // Random phase: slowly changing inputs so stalls run long enough to block.
        rv = '0;
        rr = '0;
        ri = '0;
        for (int c = 0; c < 4000; c++) begin
            for (int i = 0; i < NumCh; i++) begin
                if ($urandom_range(0, 9) == 0) rv[i] = ~rv[i];
                if ($urandom_range(0, 9) == 0) rr[i] = ~rr[i];
                if ($urandom_range(0, 15) == 0) ri[i] = ~ri[i];
            end
            drive(rv, rr, ri, $urandom_range(0, 3) == 0, $urandom_range(0, 99) != 0);
            reset = ($urandom_range(0, 499) == 0);
            step();
        end
        reset = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
